// File: rtl/card_dealer.sv
// Blackjack card dealer: free-running LFSR card source, edge-triggered deal requests
// and per-hand ace-aware scoring for player and dealer.
module card_dealer #(
  parameter logic [15:0] Seed     = 16'hACE1,
  parameter int unsigned MaxCards = 7
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       new_round_i,
  input  logic       deal_p_i,
  input  logic       deal_d_i,
  input  logic       force_en_i,
  input  logic [3:0] force_rank_i,
  output logic [5:0] p_score_o,
  output logic [5:0] d_score_o,
  output logic [3:0] p_count_o,
  output logic [3:0] d_count_o,
  output logic       p_soft_o,
  output logic       d_soft_o,
  output logic [3:0] card_o,
  output logic       card_to_dealer_o,
  output logic       card_valid_o,
  output logic       refused_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {StIdle, StCheck, StDraw, StAdd} state_e;

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        deal_p_q, deal_d_q;
  logic        pend_p_q, pend_p_d, pend_d_q, pend_d_d;
  logic        tgt_q, tgt_d;
  logic [3:0]  draw_q, draw_d;
  logic [5:0]  p_raw_q, p_raw_d, d_raw_q, d_raw_d;
  logic        p_ace_q, p_ace_d, d_ace_q, d_ace_d;
  logic [3:0]  p_cnt_q, p_cnt_d, d_cnt_q, d_cnt_d;
  logic [3:0]  card_q, card_d;
  logic        to_dealer_q, to_dealer_d;
  logic        valid_q, valid_d;
  logic        refused_q, refused_d;

  logic [3:0]  rank, value;
  logic        rank_ok;
  logic [5:0]  tgt_score;
  logic [3:0]  tgt_cnt;
  logic        edge_p, edge_d;

  // Ace counts as 11 only while the hard total leaves room for the extra 10.
  function automatic logic soft_of(input logic [5:0] r, input logic a);
    return a && (r <= 6'd11);
  endfunction

  function automatic logic [5:0] score_of(input logic [5:0] r, input logic a);
    return soft_of(r, a) ? r + 6'd10 : r;
  endfunction

  assign lfsr_d  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  assign rank    = force_en_i ? force_rank_i : lfsr_q[3:0];
  assign rank_ok = (rank >= 4'd1) && (rank <= 4'd13);
  assign value   = (rank > 4'd10) ? 4'd10 : rank;

  assign tgt_score = tgt_q ? score_of(d_raw_q, d_ace_q) : score_of(p_raw_q, p_ace_q);
  assign tgt_cnt   = tgt_q ? d_cnt_q : p_cnt_q;

  assign edge_p = deal_p_i & ~deal_p_q;
  assign edge_d = deal_d_i & ~deal_d_q;

  always_comb begin
    state_d     = state_q;
    pend_p_d    = pend_p_q;
    pend_d_d    = pend_d_q;
    tgt_d       = tgt_q;
    draw_d      = draw_q;
    p_raw_d     = p_raw_q;
    d_raw_d     = d_raw_q;
    p_ace_d     = p_ace_q;
    d_ace_d     = d_ace_q;
    p_cnt_d     = p_cnt_q;
    d_cnt_d     = d_cnt_q;
    card_d      = card_q;
    to_dealer_d = to_dealer_q;
    valid_d     = 1'b0;
    refused_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pend_p_q) begin
          tgt_d   = 1'b0;
          state_d = StCheck;
        end else if (pend_d_q) begin
          tgt_d   = 1'b1;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if ((tgt_score > 6'd21) || (tgt_cnt == 4'(MaxCards))) begin
          if (tgt_q) pend_d_d = 1'b0;
          else       pend_p_d = 1'b0;
          refused_d = 1'b1;
          state_d   = StIdle;
        end else begin
          state_d = StDraw;
        end
      end
      StDraw: begin
        if (rank_ok) begin
          draw_d  = value;
          state_d = StAdd;
        end
      end
      StAdd: begin
        if (tgt_q) begin
          d_raw_d  = d_raw_q + {2'b00, draw_q};
          d_ace_d  = d_ace_q | (draw_q == 4'd1);
          d_cnt_d  = d_cnt_q + 4'd1;
          pend_d_d = 1'b0;
        end else begin
          p_raw_d  = p_raw_q + {2'b00, draw_q};
          p_ace_d  = p_ace_q | (draw_q == 4'd1);
          p_cnt_d  = p_cnt_q + 4'd1;
          pend_p_d = 1'b0;
        end
        card_d      = draw_q;
        to_dealer_d = tgt_q;
        valid_d     = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Judged on the pre-cycle pending bit: an edge while already pending is dropped.
    if (edge_p && !pend_p_q) pend_p_d = 1'b1;
    if (edge_d && !pend_d_q) pend_d_d = 1'b1;

    if (new_round_i) begin
      state_d     = StIdle;
      pend_p_d    = 1'b0;
      pend_d_d    = 1'b0;
      p_raw_d     = '0;
      d_raw_d     = '0;
      p_ace_d     = 1'b0;
      d_ace_d     = 1'b0;
      p_cnt_d     = '0;
      d_cnt_d     = '0;
      card_d      = '0;
      to_dealer_d = 1'b0;
      valid_d     = 1'b0;
      refused_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      lfsr_q      <= Seed;
      deal_p_q    <= 1'b0;
      deal_d_q    <= 1'b0;
      pend_p_q    <= 1'b0;
      pend_d_q    <= 1'b0;
      tgt_q       <= 1'b0;
      draw_q      <= '0;
      p_raw_q     <= '0;
      d_raw_q     <= '0;
      p_ace_q     <= 1'b0;
      d_ace_q     <= 1'b0;
      p_cnt_q     <= '0;
      d_cnt_q     <= '0;
      card_q      <= '0;
      to_dealer_q <= 1'b0;
      valid_q     <= 1'b0;
      refused_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      deal_p_q    <= deal_p_i;
      deal_d_q    <= deal_d_i;
      pend_p_q    <= pend_p_d;
      pend_d_q    <= pend_d_d;
      tgt_q       <= tgt_d;
      draw_q      <= draw_d;
      p_raw_q     <= p_raw_d;
      d_raw_q     <= d_raw_d;
      p_ace_q     <= p_ace_d;
      d_ace_q     <= d_ace_d;
      p_cnt_q     <= p_cnt_d;
      d_cnt_q     <= d_cnt_d;
      card_q      <= card_d;
      to_dealer_q <= to_dealer_d;
      valid_q     <= valid_d;
      refused_q   <= refused_d;
    end
  end

  assign p_score_o        = score_of(p_raw_q, p_ace_q);
  assign d_score_o        = score_of(d_raw_q, d_ace_q);
  assign p_soft_o         = soft_of(p_raw_q, p_ace_q);
  assign d_soft_o         = soft_of(d_raw_q, d_ace_q);
  assign p_count_o        = p_cnt_q;
  assign d_count_o        = d_cnt_q;
  assign card_o           = card_q;
  assign card_to_dealer_o = to_dealer_q;
  assign card_valid_o     = valid_q;
  assign refused_o        = refused_q;
  assign busy_o           = (state_q != StIdle) | pend_p_q | pend_d_q;

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: transaction-level hand/LFSR model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_card_dealer;

  localparam logic [15:0] SeedV = 16'hACE1;
  localparam int          MaxC  = 7;

  logic       clk, rst, new_round, deal_p, deal_d, force_en;
  logic [3:0] force_rank;
  logic [5:0] p_score, d_score;
  logic [3:0] p_count, d_count, card;
  logic       p_soft, d_soft, card_to_dealer, card_valid, refused, busy;

  card_dealer #(.Seed(SeedV), .MaxCards(MaxC)) dut (
    .clk_i(clk), .rst_i(rst), .new_round_i(new_round), .deal_p_i(deal_p), .deal_d_i(deal_d),
    .force_en_i(force_en), .force_rank_i(force_rank),
    .p_score_o(p_score), .d_score_o(d_score), .p_count_o(p_count), .d_count_o(d_count),
    .p_soft_o(p_soft), .d_soft_o(d_soft), .card_o(card), .card_to_dealer_o(card_to_dealer),
    .card_valid_o(card_valid), .refused_o(refused), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_lfsr;
  bit   m_prev_p, m_prev_d, m_pp, m_pd, m_active, m_have;
  int   m_tgt, m_tstart, m_draw, cyc;
  int   m_r[2], m_n[2];
  bit   m_a[2];
  int   e_card;
  bit   e_ctd, e_valid, e_ref;

  function automatic int hand_score(input int r, input bit a);
    if (a && (r + 10 <= 21)) return r + 10;
    return r;
  endfunction

  function automatic bit hand_soft(input int r, input bit a);
    return a && (r + 10 <= 21);
  endfunction

  always @(posedge clk) begin
    bit ep, ed, old_pp, old_pd;
    int rk;
    if (rst) begin
      m_lfsr = SeedV; m_prev_p = 0; m_prev_d = 0; m_pp = 0; m_pd = 0; m_active = 0;
      m_have = 0; m_tgt = 0; m_tstart = 0; m_draw = 0; cyc = 0;
      for (int h = 0; h < 2; h++) begin m_r[h] = 0; m_n[h] = 0; m_a[h] = 0; end
      e_card = 0; e_ctd = 0; e_valid = 0; e_ref = 0;
    end else begin
      e_valid = 0; e_ref = 0;
      ep = deal_p && !m_prev_p;
      ed = deal_d && !m_prev_d;
      m_prev_p = deal_p; m_prev_d = deal_d;
      if (new_round) begin
        for (int h = 0; h < 2; h++) begin m_r[h] = 0; m_n[h] = 0; m_a[h] = 0; end
        m_pp = 0; m_pd = 0; m_active = 0; e_card = 0; e_ctd = 0;
      end else begin
        old_pp = m_pp; old_pd = m_pd;
        if (m_active) begin
          if (cyc == m_tstart + 1) begin
            if (hand_score(m_r[m_tgt], m_a[m_tgt]) > 21 || m_n[m_tgt] == MaxC) begin
              e_ref = 1; m_active = 0;
              if (m_tgt == 0) m_pp = 0; else m_pd = 0;
            end
          end else if (!m_have) begin
            rk = force_en ? int'(force_rank) : int'(m_lfsr[3:0]);
            if (rk >= 1 && rk <= 13) begin m_draw = (rk > 10) ? 10 : rk; m_have = 1; end
          end else begin
            m_r[m_tgt] += m_draw; m_n[m_tgt] += 1;
            if (m_draw == 1) m_a[m_tgt] = 1;
            e_valid = 1; e_card = m_draw; e_ctd = (m_tgt == 1); m_active = 0;
            if (m_tgt == 0) m_pp = 0; else m_pd = 0;
          end
        end else if (m_pp || m_pd) begin
          m_active = 1; m_have = 0; m_tstart = cyc; m_tgt = m_pp ? 0 : 1;
        end
        if (ep && !old_pp) m_pp = 1;
        if (ed && !old_pd) m_pd = 1;
      end
      cyc++;
      m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("cardValid", card_valid, e_valid);
      chk("refused", refused, e_ref);
      chk("busy", busy, m_active || m_pp || m_pd);
      chk("card", card, e_card);
      chk("cardToDealer", card_to_dealer, e_ctd);
      chk("pScore", p_score, hand_score(m_r[0], m_a[0]));
      chk("dScore", d_score, hand_score(m_r[1], m_a[1]));
      chk("pCount", p_count, m_n[0]);
      chk("dCount", d_count, m_n[1]);
      chk("pSoft", p_soft, hand_soft(m_r[0], m_a[0]));
      chk("dSoft", d_soft, hand_soft(m_r[1], m_a[1]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic round_clear();
    new_round = 1; tick(); new_round = 0; tick();
  endtask

  // Pulses the requested switches for one cycle, then waits for the next pulse.
  task automatic deal(input bit p, input bit d, input int bound,
                      output int lat, output bit got_v, output bit got_r);
    lat = -1; got_v = 0; got_r = 0;
    deal_p = p; deal_d = d;
    for (int n = 1; n <= bound; n++) begin
      tick();
      deal_p = 0; deal_d = 0;
      if (card_valid || refused) begin
        lat = n - 1; got_v = card_valid; got_r = refused;
        break;
      end
    end
    chk("pulse_seen", int'(lat >= 0), 1);
  endtask

  int lat, pulses;
  bit gv, gr;

  initial begin
    rst = 1; new_round = 0; deal_p = 0; deal_d = 0; force_en = 0; force_rank = 0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_pScore", p_score, 0); chk("rst_dScore", d_score, 0);
    chk("rst_pCount", p_count, 0); chk("rst_card", card, 0);
    chk("rst_valid", card_valid, 0); chk("rst_busy", busy, 0);
    @(posedge clk); #1 rst = 0;
    tick();

    // Single forced card, minimum latency.
    force_en = 1; force_rank = 5;
    deal(1, 0, 20, lat, gv, gr);
    chk("t1_lat", lat, 4); chk("t1_valid", gv, 1); chk("t1_pScore", p_score, 5);
    chk("t1_pCount", p_count, 1); chk("t1_card", card, 5); chk("t1_ctd", card_to_dealer, 0);

    // Soft ace then hardening.
    round_clear();
    force_rank = 1;  deal(1, 0, 20, lat, gv, gr);
    force_rank = 12; deal(1, 0, 20, lat, gv, gr);
    chk("t2_pScore21", p_score, 21); chk("t2_soft", p_soft, 1);
    force_rank = 9;  deal(1, 0, 20, lat, gv, gr);
    chk("t2_pScore20", p_score, 20); chk("t2_hard", p_soft, 0); chk("t2_pCount", p_count, 3);

    // Bust then refusal.
    round_clear();
    force_rank = 13; deal(1, 0, 20, lat, gv, gr);
    force_rank = 13; deal(1, 0, 20, lat, gv, gr);
    force_rank = 2;  deal(1, 0, 20, lat, gv, gr);
    chk("t3_pScore22", p_score, 22);
    deal(1, 0, 20, lat, gv, gr);
    chk("t3_refused", gr, 1); chk("t3_ref_lat", lat, 2);
    chk("t3_pScore", p_score, 22); chk("t3_pCount", p_count, 3);

    // Simultaneous requests: player first.
    round_clear();
    force_rank = 3;
    deal(1, 1, 20, lat, gv, gr);
    chk("t4_first_ctd", card_to_dealer, 0); chk("t4_first_p", p_score, 3);
    chk("t4_first_d", d_score, 0);
    deal(0, 0, 20, lat, gv, gr);
    chk("t4_second_valid", gv, 1); chk("t4_second_ctd", card_to_dealer, 1);
    chk("t4_dScore", d_score, 3); chk("t4_pScore", p_score, 3);

    // Three rejected ranks stretch latency to 7.
    round_clear();
    force_rank = 15; deal_p = 1; lat = -1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      deal_p = 0;
      if (n == 6) force_rank = 7;
      if (card_valid) begin lat = n - 1; break; end
    end
    chk("t5_lat", lat, 7); chk("t5_card", card, 7);

    // newRound aborts a transaction stuck in DRAW.
    round_clear();
    force_rank = 15; deal_p = 1; tick(); deal_p = 0;
    repeat (5) tick();
    new_round = 1; tick(); tick(); new_round = 0; force_rank = 5;
    pulses = 0;
    for (int n = 0; n < 10; n++) begin tick(); if (card_valid || refused) pulses++; end
    chk("t6_pulses", pulses, 0); chk("t6_pScore", p_score, 0);
    chk("t6_pCount", p_count, 0); chk("t6_busy", busy, 0);

    // Free-running LFSR deals across rounds.
    force_en = 0;
    for (int i = 0; i < 200; i++) begin
      if (i % 10 == 0) round_clear();
      repeat ($urandom_range(0, 2)) tick();
      if ($urandom_range(0, 1) == 1) deal(1, 0, 60, lat, gv, gr);
      else deal(0, 1, 60, lat, gv, gr);
      if (gv) chk("t7_card_range", int'(card >= 1 && card <= 10), 1);
    end

    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
